// File: rtl/ad9833_pkg.sv
// Shared constants for the AD9833 serial-bus receiver.
// Address codes, control-bit positions and update-strobe indices.
package ad9833_pkg;

    localparam int WORD_W  = 16;
    localparam int FREQ_W  = 28;
    localparam int HALF_W  = 14;
    localparam int PHASE_W = 12;

    localparam int B28_BIT   = 13;
    localparam int HLB_BIT   = 12;
    localparam int RESET_BIT = 8;
    localparam int PSEL_BIT  = 13;

    localparam int UPD_CTRL = 0;
    localparam int UPD_F0   = 1;
    localparam int UPD_F1   = 2;
    localparam int UPD_PH0  = 3;
    localparam int UPD_PH1  = 4;
    localparam int UPD_W    = 5;

    typedef enum logic [1:0] {
        ADDR_CTRL  = 2'b00,
        ADDR_FREQ0 = 2'b01,
        ADDR_FREQ1 = 2'b10,
        ADDR_PHASE = 2'b11
    } addr_e;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } deser_state_e;

endpackage

// File: rtl/ad9833_bit_deser.sv
// Pin synchroniser, edge detect and 16-bit MSB-first deserialiser
// for the AD9833 SCLK/FSYNC/SDATA bus.
module ad9833_bit_deser
    import ad9833_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              sclk_i,
    input  logic              fsync_i,
    input  logic              sdata_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o,
    output logic              frame_err_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] fsync_sync_q;
    logic [SYNC_STAGES-1:0] sdata_sync_q;
    logic                   sclk_prev_q;
    logic                   fsync_prev_q;

    deser_state_e      state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_W-2:0] shift_q, shift_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic sclk_s, fsync_s, sdata_s;
    logic sclk_fall, fsync_fall, fsync_rise;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign fsync_s = fsync_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];

    assign sclk_fall  = sclk_prev_q & ~sclk_s;
    assign fsync_fall = fsync_prev_q & ~fsync_s;
    assign fsync_rise = ~fsync_prev_q & fsync_s;

    // Chains reset low so a frame already in flight at reset release is never entered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_sync_q  <= '0;
            fsync_sync_q <= '0;
            sdata_sync_q <= '0;
            sclk_prev_q  <= 1'b0;
            fsync_prev_q <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            fsync_sync_q <= {fsync_sync_q[SYNC_STAGES-2:0], fsync_i};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_i};
            sclk_prev_q  <= sclk_s;
            fsync_prev_q <= fsync_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fsync_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 4'd0;
                end
            end
            ST_SHIFT: begin
                // Bit is taken before a coincident FSYNC rise is judged.
                if (sclk_fall) begin
                    shift_d   = {shift_q[WORD_W-3:0], sdata_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        valid_d = 1'b1;
                        word_d  = {shift_q, sdata_s};
                    end
                end
                if (fsync_rise) begin
                    state_d   = ST_IDLE;
                    err_d     = (bit_cnt_d != 4'd0);
                    bit_cnt_d = 4'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign word_valid_o = valid_q;
    assign word_o       = word_q;
    assign frame_err_o  = err_q;

endmodule

// File: rtl/ad9833_bus_rx.sv
// AD9833 bus receiver: deserialised words decoded into a shadow of
// the device registers (CTRL, FREQ0/1, PHASE0/1).
module ad9833_bus_rx
    import ad9833_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] CTRL_INIT   = 16'h0100
) (
    input  logic               sys_clk_i,
    input  logic               rst_n_i,
    input  logic               sclk_i,
    input  logic               fsync_i,
    input  logic               sdata_i,
    output logic               word_valid_o,
    output logic [WORD_W-1:0]  word_o,
    output logic [UPD_W-1:0]   reg_update_o,
    output logic [WORD_W-1:0]  ctrl_o,
    output logic [FREQ_W-1:0]  freq0_o,
    output logic [FREQ_W-1:0]  freq1_o,
    output logic [PHASE_W-1:0] phase0_o,
    output logic [PHASE_W-1:0] phase1_o,
    output logic               frame_err_o,
    output logic [15:0]        word_cnt_o
);

    logic              word_valid;
    logic [WORD_W-1:0] word;
    addr_e             addr;
    logic              fsel;

    logic [WORD_W-1:0]             ctrl_q, ctrl_d;
    logic [1:0][FREQ_W-1:0]        freq_q, freq_d;
    logic [1:0][HALF_W-1:0]        lsb_q, lsb_d;
    logic [1:0]                    pend_q, pend_d;
    logic [PHASE_W-1:0]            phase0_q, phase0_d;
    logic [PHASE_W-1:0]            phase1_q, phase1_d;
    logic [15:0]                   word_cnt_q, word_cnt_d;
    logic [UPD_W-1:0]              upd;

    ad9833_bit_deser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deser (
        .clk_i        (sys_clk_i),
        .rst_n_i      (rst_n_i),
        .sclk_i       (sclk_i),
        .fsync_i      (fsync_i),
        .sdata_i      (sdata_i),
        .word_valid_o (word_valid),
        .word_o       (word),
        .frame_err_o  (frame_err_o)
    );

    assign addr = addr_e'(word[15:14]);
    assign fsel = word[15];

    always_comb begin
        ctrl_d     = ctrl_q;
        freq_d     = freq_q;
        lsb_d      = lsb_q;
        pend_d     = pend_q;
        phase0_d   = phase0_q;
        phase1_d   = phase1_q;
        word_cnt_d = word_cnt_q;
        upd        = '0;
        if (word_valid) begin
            word_cnt_d = word_cnt_q + 16'd1;
            unique case (addr)
                ADDR_CTRL: begin
                    ctrl_d         = word;
                    pend_d         = '0;
                    upd[UPD_CTRL]  = 1'b1;
                end
                ADDR_FREQ0, ADDR_FREQ1: begin
                    if (ctrl_q[B28_BIT]) begin
                        // 28-bit mode: first write parks the LSBs, second completes.
                        if (!pend_q[fsel]) begin
                            lsb_d[fsel]  = word[HALF_W-1:0];
                            pend_d[fsel] = 1'b1;
                        end else begin
                            freq_d[fsel] = {word[HALF_W-1:0], lsb_q[fsel]};
                            pend_d[fsel] = 1'b0;
                            upd[UPD_F0]  = ~fsel;
                            upd[UPD_F1]  = fsel;
                        end
                    end else begin
                        if (ctrl_q[HLB_BIT]) begin
                            freq_d[fsel][FREQ_W-1:HALF_W] = word[HALF_W-1:0];
                        end else begin
                            freq_d[fsel][HALF_W-1:0] = word[HALF_W-1:0];
                        end
                        upd[UPD_F0] = ~fsel;
                        upd[UPD_F1] = fsel;
                    end
                end
                ADDR_PHASE: begin
                    if (word[PSEL_BIT]) begin
                        phase1_d     = word[PHASE_W-1:0];
                        upd[UPD_PH1] = 1'b1;
                    end else begin
                        phase0_d     = word[PHASE_W-1:0];
                        upd[UPD_PH0] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q     <= CTRL_INIT;
            freq_q     <= '0;
            lsb_q      <= '0;
            pend_q     <= '0;
            phase0_q   <= '0;
            phase1_q   <= '0;
            word_cnt_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            freq_q     <= freq_d;
            lsb_q      <= lsb_d;
            pend_q     <= pend_d;
            phase0_q   <= phase0_d;
            phase1_q   <= phase1_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_valid_o = word_valid;
    assign word_o       = word;
    assign reg_update_o = upd;
    assign ctrl_o       = ctrl_q;
    assign freq0_o      = freq_q[0];
    assign freq1_o      = freq_q[1];
    assign phase0_o     = phase0_q;
    assign phase1_o     = phase1_q;
    assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_ad9833_bus_rx.sv
// Scoreboard bench for ad9833_bus_rx: directed SPI frames, expected
// words and shadow states queued by the driver, checked by a monitor.
module tb_ad9833_bus_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b1;
    logic        fsync = 1'b1;
    logic        sdata = 1'b0;
    logic        word_valid;
    logic [15:0] word;
    logic [4:0]  reg_update;
    logic [15:0] ctrl;
    logic [27:0] freq0, freq1;
    logic [11:0] phase0, phase1;
    logic        frame_err;
    logic [15:0] word_cnt;

    typedef struct packed {
        logic [15:0] w;
        logic [4:0]  upd;
        logic [15:0] ctrl;
        logic [27:0] f0;
        logic [27:0] f1;
        logic [11:0] p0;
        logic [11:0] p1;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_ferr = 0;
    int   exp_ferr = 0;

    ad9833_bus_rx #(
        .SYNC_STAGES (2),
        .CTRL_INIT   (16'h0100)
    ) dut (
        .sys_clk_i    (clk),
        .rst_n_i      (rst_n),
        .sclk_i       (sclk),
        .fsync_i      (fsync),
        .sdata_i      (sdata),
        .word_valid_o (word_valid),
        .word_o       (word),
        .reg_update_o (reg_update),
        .ctrl_o       (ctrl),
        .freq0_o      (freq0),
        .freq1_o      (freq1),
        .phase0_o     (phase0),
        .phase1_o     (phase1),
        .frame_err_o  (frame_err),
        .word_cnt_o   (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_w(input logic [15:0] w, input logic [4:0] upd,
                            input logic [15:0] c, input logic [27:0] f0,
                            input logic [27:0] f1, input logic [11:0] p0,
                            input logic [11:0] p1, input logic [15:0] cnt);
        exp_t e;
        e = '{w: w, upd: upd, ctrl: c, f0: f0, f1: f1, p0: p0, p1: p1, cnt: cnt};
        exp_q.push_back(e);
    endtask

    // 10 MHz SCLK: data changes on the rising edge, device samples on the fall.
    task automatic fs_low();
        fsync = 1'b0;
        #100;
    endtask

    task automatic shift_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            sclk  = 1'b1;
            sdata = w[15-i];
            #50;
            sclk  = 1'b0;
            #50;
        end
    endtask

    task automatic fs_high();
        sclk = 1'b1;
        #50;
        fsync = 1'b1;
        #300;
    endtask

    task automatic send_word(input logic [15:0] w);
        fs_low();
        shift_bits(w, 16);
        fs_high();
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        chk("sb_left", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_err) n_ferr++;
            if (word_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", word, 16'hxxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", word, e.w);
                    chk("reg_update", reg_update, e.upd);
                    @(negedge clk);
                    chk("ctrl", ctrl, e.ctrl);
                    chk("freq0", freq0, e.f0);
                    chk("freq1", freq1, e.f1);
                    chk("phase0", phase0, e.p0);
                    chk("phase1", phase1, e.p1);
                    chk("word_cnt", word_cnt, e.cnt);
                end
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctrl"}, ctrl, 16'h0100);
        chk({tag, "_freq0"}, freq0, 0);
        chk({tag, "_freq1"}, freq1, 0);
        chk({tag, "_phase0"}, phase0, 0);
        chk({tag, "_phase1"}, phase1, 0);
        chk({tag, "_word_cnt"}, word_cnt, 0);
        chk({tag, "_word"}, word, 0);
        chk({tag, "_pulses"}, {word_valid, reg_update, frame_err}, 0);
    endtask

    initial begin : stim
        logic [15:0] tail;
        #37;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk_reset_state("rst");

        // 28-bit FREQ0 load in two halves
        expect_w(16'h2100, 5'b00001, 16'h2100, 28'h0, 28'h0, 12'h0, 12'h0, 16'd1);
        send_word(16'h2100);
        expect_w(16'h4000, 5'b00000, 16'h2100, 28'h0, 28'h0, 12'h0, 12'h0, 16'd2);
        send_word(16'h4000);
        expect_w(16'h4001, 5'b00010, 16'h2100, 28'h0004000, 28'h0, 12'h0, 12'h0, 16'd3);
        send_word(16'h4001);

        // HLB=1: upper half of FREQ1
        expect_w(16'h1000, 5'b00001, 16'h1000, 28'h0004000, 28'h0, 12'h0, 12'h0, 16'd4);
        send_word(16'h1000);
        expect_w(16'h8ABC, 5'b00100, 16'h1000, 28'h0004000, 28'h2AF0000, 12'h0, 12'h0, 16'd5);
        send_word(16'h8ABC);

        // two words in one FSYNC-low frame
        expect_w(16'hC123, 5'b01000, 16'h1000, 28'h0004000, 28'h2AF0000, 12'h123, 12'h0, 16'd6);
        expect_w(16'hE456, 5'b10000, 16'h1000, 28'h0004000, 28'h2AF0000, 12'h123, 12'h456, 16'd7);
        fs_low();
        shift_bits(16'hC123, 16);
        shift_bits(16'hE456, 16);
        fs_high();
        drain();

        // truncated frame after 9 bits
        exp_ferr++;
        fs_low();
        shift_bits(16'h4FFF, 9);
        fs_high();
        drain();
        chk("ferr_word_cnt", word_cnt, 16'd7);
        chk("ferr_freq0", freq0, 28'h0004000);
        chk("ferr_phase0", phase0, 12'h123);
        chk("ferr_cnt", n_ferr, exp_ferr);
        expect_w(16'hC0AA, 5'b01000, 16'h1000, 28'h0004000, 28'h2AF0000, 12'h0AA, 12'h456, 16'd8);
        send_word(16'hC0AA);
        drain();

        // async reset at bit 7 of a FREQ0 word
        fs_low();
        shift_bits(16'h4123, 7);
        rst_n = 1'b0;
        #20;
        chk_reset_state("mid_rst");
        #20;
        rst_n = 1'b1;
        tail = 16'h4123 << 7;
        shift_bits(tail, 9);
        fs_high();
        repeat (4) @(negedge clk);
        chk_reset_state("post_rst");
        expect_w(16'h5555, 5'b00010, 16'h0100, 28'h0001555, 28'h0, 12'h0, 12'h0, 16'd1);
        send_word(16'h5555);
        drain();

        chk("frame_err_total", n_ferr, exp_ferr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
